ixc_gfifo_param: RTL and testbench

//  Parametrised single-clock FIFO with 64-bit cumulative read/write counters.

---
 rtl/ixc_gfifo_param_if.sv | 22 ++
 rtl/ixc_gfifo_param.sv | 93 +++++++++
 tb/tb_ixc_gfifo_param.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ixc_gfifo_param_if.sv
// Ready/valid handshake bundle for ixc_gfifo_param: write side from the producer, read side to the consumer.
// The master modport is the producer/consumer pair; the slave modport is the FIFO.
interface ixc_gfifo_param_if #(
    parameter int WIDTH = 32
);
    logic             wrValid;
    logic             wrReady;
    logic [WIDTH-1:0] wrData;
    logic             rdValid;
    logic             rdReady;
    logic [WIDTH-1:0] rdData;

    modport master (
        output wrValid, wrData, rdReady,
        input  wrReady, rdValid, rdData
    );

    modport slave (
        input  wrValid, wrData, rdReady,
        output wrReady, rdValid, rdData
    );
endinterface

// File: rtl/ixc_gfifo_param.sv
// Parametrised single-clock first-word-fall-through FIFO with cumulative write/read/drop counters
// that the host polls to reconcile traffic between the transactor and emulator sides.
module ixc_gfifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 256,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int DROP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     flush,
    ixc_gfifo_param_if.slave         fifoIf,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almostFull,
    output logic                     almostEmpty,
    output logic [63:0]              wrCnt,
    output logic [63:0]              rdCnt,
    output logic [31:0]              dropCnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [31:0]   AF_LEVEL   = 32'(AF_THRESH);
    localparam logic [31:0]   AE_LEVEL   = 32'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [LW-1:0]    levelQ;
    logic [31:0]      levelWide;
    logic             full;
    logic             empty;
    logic             wrFire;
    logic             rdFire;
    logic             dropFire;

    assign full      = (levelQ == FULL_LEVEL);
    assign empty     = (levelQ == '0);
    assign levelWide = 32'(levelQ);

    // wrReady is a function of occupancy only, so there is no path from rdReady
    assign fifoIf.wrReady = (DROP_MODE != 0) ? 1'b1 : !full;
    assign fifoIf.rdValid = !empty;
    assign fifoIf.rdData  = mem[rdPtr];

    // A full FIFO never accepts a write, even when a read frees a slot the same cycle
    assign wrFire   = fifoIf.wrValid && !full && !flush;
    assign rdFire   = fifoIf.rdValid && fifoIf.rdReady && !flush;
    assign dropFire = (DROP_MODE != 0) && fifoIf.wrValid && full && !flush;

    assign level       = levelQ;
    assign almostFull  = (levelWide >= AF_LEVEL);
    assign almostEmpty = (levelWide <= AE_LEVEL);

    always_ff @(posedge clk) begin
        if (wrFire) begin
            mem[wrPtr] <= fifoIf.wrData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            levelQ  <= '0;
            wrCnt   <= '0;
            rdCnt   <= '0;
            dropCnt <= '0;
        end else if (flush) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            levelQ <= '0;
        end else begin
            if (wrFire) begin
                wrPtr <= wrPtr + AW'(1);
                wrCnt <= wrCnt + 64'd1;
            end
            if (rdFire) begin
                rdPtr <= rdPtr + AW'(1);
                rdCnt <= rdCnt + 64'd1;
            end
            if (dropFire) begin
                dropCnt <= dropCnt + 32'd1;
            end
            case ({wrFire, rdFire})
                2'b10:   levelQ <= levelQ + LW'(1);
                2'b01:   levelQ <= levelQ - LW'(1);
                default: levelQ <= levelQ;
            endcase
        end
    end
endmodule

// File: tb/tb_ixc_gfifo_param.sv
// Bench for ixc_gfifo_param: a backpressure instance and a drop-mode instance, both 8 deep,
// checked against a reference queue model plus hand-derived vector expectations.
module tb_ixc_gfifo_param;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rstN;
    logic bpFlush;
    logic dpFlush;
    always #5 clk = ~clk;

    ixc_gfifo_param_if #(.WIDTH(W)) bpIf ();
    ixc_gfifo_param_if #(.WIDTH(W)) dpIf ();

    logic [LW-1:0] bpLevel, dpLevel;
    logic          bpAf, bpAe, dpAf, dpAe;
    logic [63:0]   bpWrCnt, bpRdCnt, dpWrCnt, dpRdCnt;
    logic [31:0]   bpDropCnt, dpDropCnt;

    ixc_gfifo_param #(.WIDTH(W), .DEPTH(D), .DROP_MODE(0)) dutBp (
        .clk(clk), .rstN(rstN), .flush(bpFlush), .fifoIf(bpIf.slave),
        .level(bpLevel), .almostFull(bpAf), .almostEmpty(bpAe),
        .wrCnt(bpWrCnt), .rdCnt(bpRdCnt), .dropCnt(bpDropCnt)
    );

    ixc_gfifo_param #(.WIDTH(W), .DEPTH(D), .DROP_MODE(1)) dutDp (
        .clk(clk), .rstN(rstN), .flush(dpFlush), .fifoIf(dpIf.slave),
        .level(dpLevel), .almostFull(dpAf), .almostEmpty(dpAe),
        .wrCnt(dpWrCnt), .rdCnt(dpRdCnt), .dropCnt(dpDropCnt)
    );

    int checks   = 0;
    int failures = 0;
    bit sel      = 1'b0;   // 0: backpressure instance under test, 1: drop-mode instance

    int              mLevel;
    longint unsigned mWr;
    longint unsigned mRd;
    int unsigned     mDrop;
    logic [W-1:0]    q [$];

    logic [LW-1:0] sLevel;
    logic          sRdValid, sWrReady, sAf, sAe;
    logic [W-1:0]  sRdData;
    logic [63:0]   sWrCnt, sRdCnt;
    logic [31:0]   sDropCnt;

    always_comb begin
        sLevel   = sel ? dpLevel      : bpLevel;
        sRdValid = sel ? dpIf.rdValid : bpIf.rdValid;
        sWrReady = sel ? dpIf.wrReady : bpIf.wrReady;
        sRdData  = sel ? dpIf.rdData  : bpIf.rdData;
        sAf      = sel ? dpAf         : bpAf;
        sAe      = sel ? dpAe         : bpAe;
        sWrCnt   = sel ? dpWrCnt      : bpWrCnt;
        sRdCnt   = sel ? dpRdCnt      : bpRdCnt;
        sDropCnt = sel ? dpDropCnt    : bpDropCnt;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mLevel = 0;
        mWr    = 0;
        mRd    = 0;
        mDrop  = 0;
        q.delete();
    endtask

    task automatic checkOutputs();
        chk("level",       64'(sLevel),   64'(mLevel));
        chk("rdValid",     64'(sRdValid), 64'(mLevel != 0));
        chk("wrReady",     64'(sWrReady), 64'(sel ? 1'b1 : (mLevel < D)));
        chk("almostFull",  64'(sAf),      64'(mLevel >= D - 4));
        chk("almostEmpty", 64'(sAe),      64'(mLevel <= 4));
        chk("wrCnt",       sWrCnt,        mWr);
        chk("rdCnt",       sRdCnt,        mRd);
        chk("dropCnt",     64'(sDropCnt), 64'(mDrop));
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, "BpLevel"},   64'(bpLevel),      64'd0);
        chk({tag, "BpRdValid"}, 64'(bpIf.rdValid), 64'd0);
        chk({tag, "BpWrReady"}, 64'(bpIf.wrReady), 64'd1);
        chk({tag, "BpAe"},      64'(bpAe),         64'd1);
        chk({tag, "BpAf"},      64'(bpAf),         64'd0);
        chk({tag, "BpWrCnt"},   bpWrCnt,           64'd0);
        chk({tag, "BpRdCnt"},   bpRdCnt,           64'd0);
        chk({tag, "DpLevel"},   64'(dpLevel),      64'd0);
        chk({tag, "DpRdValid"}, 64'(dpIf.rdValid), 64'd0);
        chk({tag, "DpAe"},      64'(dpAe),         64'd1);
        chk({tag, "DpAf"},      64'(dpAf),         64'd0);
        chk({tag, "DpWrCnt"},   dpWrCnt,           64'd0);
        chk({tag, "DpRdCnt"},   dpRdCnt,           64'd0);
        chk({tag, "DpDropCnt"}, 64'(dpDropCnt),    64'd0);
    endtask

    task automatic idleInputs();
        bpIf.wrValid = 1'b0; bpIf.wrData = '0; bpIf.rdReady = 1'b0; bpFlush = 1'b0;
        dpIf.wrValid = 1'b0; dpIf.wrData = '0; dpIf.rdReady = 1'b0; dpFlush = 1'b0;
    endtask

    // Called at posedge+1; drives one cycle, scores the read, then checks state after the edge.
    task automatic step(input bit wv, input logic [W-1:0] wd, input bit rr, input bit fl);
        bit           wf, rf, df, mFull;
        logic [W-1:0] exp;
        idleInputs();
        if (!sel) begin
            bpIf.wrValid = wv; bpIf.wrData = wd; bpIf.rdReady = rr; bpFlush = fl;
        end else begin
            dpIf.wrValid = wv; dpIf.wrData = wd; dpIf.rdReady = rr; dpFlush = fl;
        end
        #1;
        mFull = (mLevel == D);
        wf = wv && !mFull && !fl;
        rf = rr && (mLevel > 0) && !fl;
        df = sel && wv && mFull && !fl;
        if (rf) begin
            exp = q.pop_front();
            chk("rdData", 64'(sRdData), 64'(exp));
        end
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            mLevel = 0;
        end else begin
            if (wf) begin
                q.push_back(wd);
                mLevel++;
                mWr++;
            end
            if (rf) begin
                mLevel--;
                mRd++;
            end
            if (df) mDrop++;
        end
        checkOutputs();
    endtask

    typedef struct {
        bit           wv;
        logic [W-1:0] wd;
        bit           rr;
        bit           fl;
        int           expLevel;
        bit           expWrReady;
    } vec_t;

    vec_t vecs [$];

    initial begin
        vec_t v;
        rstN = 1'b0;
        idleInputs();
        modelReset();

        // Fill 0..7, one rejected write when full, drain, then write-to-empty with rdReady high
        for (int i = 0; i < 8; i++) begin
            v = '{1'b1, W'(i), 1'b0, 1'b0, i + 1, (i + 1) < 8};
            vecs.push_back(v);
        end
        v = '{1'b1, 16'h0099, 1'b0, 1'b0, 8, 1'b0};
        vecs.push_back(v);
        for (int i = 0; i < 8; i++) begin
            v = '{1'b0, 16'h0000, 1'b1, 1'b0, 7 - i, 1'b1};
            vecs.push_back(v);
        end
        v = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1};
        vecs.push_back(v);
        v = '{1'b1, 16'h00A0, 1'b1, 1'b0, 1, 1'b1};
        vecs.push_back(v);

        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rstN = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].fl);
            chk("vecLevel",   64'(bpLevel),      64'(vecs[i].expLevel));
            chk("vecWrReady", 64'(bpIf.wrReady), 64'(vecs[i].expWrReady));
        end
        chk("fwftValid", 64'(bpIf.rdValid), 64'd1);
        chk("fwftData",  64'(bpIf.rdData),  64'h00A0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("drainRdCnt", bpRdCnt, 64'd9);

        // Steady state at level 4 with simultaneous read and write
        for (int i = 0; i < 4; i++) step(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, W'(16'h0200 + i), 1'b1, 1'b0);
        chk("steadyLevel", 64'(bpLevel), 64'd4);
        chk("steadyWrCnt", bpWrCnt,      64'd33);
        chk("steadyRdCnt", bpRdCnt,      64'd29);

        // Flush with a concurrent write at level 5
        step(1'b1, 16'h02FF, 1'b0, 1'b0);
        step(1'b1, 16'h0300, 1'b0, 1'b1);
        chk("flushLevel",   64'(bpLevel),      64'd0);
        chk("flushRdValid", 64'(bpIf.rdValid), 64'd0);
        chk("flushWrCnt",   bpWrCnt,           64'd34);
        step(1'b1, 16'h0301, 1'b0, 1'b0);
        chk("postFlushData", 64'(bpIf.rdData), 64'h0301);

        // Drop mode: fill, three dropped writes, then a drop alongside a read
        sel = 1'b1;
        modelReset();
        for (int i = 0; i < 8; i++) step(1'b1, W'(16'h0400 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, W'(16'h0500 + i), 1'b0, 1'b0);
        chk("dropCnt3",   64'(dpDropCnt), 64'd3);
        chk("dropWrCnt",  dpWrCnt,        64'd8);
        chk("dropLevel",  64'(dpLevel),   64'd8);
        step(1'b1, 16'h05FF, 1'b1, 1'b0);
        chk("dropRdCnt4", 64'(dpDropCnt), 64'd4);
        chk("dropLevel7", 64'(dpLevel),   64'd7);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h0600, 1'b1, 1'b0);

        // Asynchronous reset mid-burst, checked before any clock edge
        idleInputs();
        dpIf.wrValid = 1'b1; dpIf.wrData = 16'h0700; dpIf.rdReady = 1'b1;
        #2;
        rstN = 1'b0;
        #1;
        checkResetValues("asyncRst");
        @(posedge clk);
        #1;
        idleInputs();
        rstN = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        step(1'b1, 16'h0800, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        idleInputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
